// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: issue/result bundle between EX and the branch resolve unit
//   master: in_valid, funct3, rs1, rs2, pc, imm, pred_taken, pred_target, out_ready
//   slave : in_ready, out_valid, taken, redirect_pc, mispredict, illegal
interface branch_resolve_unit_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            out_valid;
    logic            out_ready;
    logic            taken;
    logic [XLEN-1:0] redirect_pc;
    logic            mispredict;
    logic            illegal;
    modport master (
        output in_valid, funct3, rs1, rs2, pc, imm, pred_taken, pred_target, out_ready,
        input  in_ready, out_valid, taken, redirect_pc, mispredict, illegal
    );
    modport slave (
        input  in_valid, funct3, rs1, rs2, pc, imm, pred_taken, pred_target, out_ready,
        output in_ready, out_valid, taken, redirect_pc, mispredict, illegal
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: pipelined RV32I branch compare, target and mispredict detection
//   clk, rst (async, active-high), flush (kills all in-flight entries)
//   stat_clr, stat_branches, stat_mispred: statistics, present only with BRU_STATS_EN
//   bus (slave): valid/ready issue of funct3/rs1/rs2/pc/imm/prediction, valid/ready result
//   LATENCY 1 decodes the result from stage-1 registers, LATENCY 2 adds a result register
module branch_resolve_unit #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                stat_clr,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispred,
    branch_resolve_unit_if.slave bus
);
    logic            s1_valid_q, s1_valid_d;
    logic            s1_eq_q, s1_lt_q, s1_ltu_q, s1_pred_taken_q;
    logic [2:0]      s1_funct3_q;
    logic [XLEN-1:0] s1_target_q, s1_pc4_q, s1_pred_target_q;
    logic            s1_adv, in_fire;
    logic            d_illegal, d_cmp, d_taken, d_mispredict;
    logic [XLEN-1:0] d_redirect;

    assign bus.in_ready = !flush && (!s1_valid_q || s1_adv);
    assign in_fire      = bus.in_valid && bus.in_ready;

    always_comb begin
        s1_valid_d = flush ? 1'b0 : in_fire ? 1'b1 : s1_adv ? 1'b0 : s1_valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q       <= 1'b0;
            s1_eq_q          <= 1'b0;
            s1_lt_q          <= 1'b0;
            s1_ltu_q         <= 1'b0;
            s1_pred_taken_q  <= 1'b0;
            s1_funct3_q      <= '0;
            s1_target_q      <= '0;
            s1_pc4_q         <= '0;
            s1_pred_target_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                s1_eq_q          <= bus.rs1 == bus.rs2;
                s1_lt_q          <= $signed(bus.rs1) < $signed(bus.rs2);
                s1_ltu_q         <= bus.rs1 < bus.rs2;
                s1_pred_taken_q  <= bus.pred_taken;
                s1_funct3_q      <= bus.funct3;
                s1_target_q      <= bus.pc + bus.imm;
                s1_pc4_q         <= bus.pc + XLEN'(4);
                s1_pred_target_q <= bus.pred_target;
            end
        end
    end

    // funct3[2:1] selects eq/lt/ltu, funct3[0] inverts the sense (BNE/BGE/BGEU)
    always_comb begin
        d_illegal    = s1_funct3_q[2:1] == 2'b01;
        d_cmp        = s1_funct3_q[2] ? (s1_funct3_q[1] ? s1_ltu_q : s1_lt_q) : s1_eq_q;
        d_taken      = !d_illegal && (d_cmp ^ s1_funct3_q[0]);
        d_redirect   = d_taken ? s1_target_q : s1_pc4_q;
        d_mispredict = !d_illegal && ((d_taken != s1_pred_taken_q) ||
                                      (d_taken && s1_pred_target_q != s1_target_q));
    end

    generate
        if (LATENCY == 2) begin : g_lat2
            logic            s2_valid_q, s2_valid_d, s2_load;
            logic            s2_taken_q, s2_mispredict_q, s2_illegal_q;
            logic [XLEN-1:0] s2_redirect_q;
            assign s1_adv  = !s2_valid_q || bus.out_ready;
            assign s2_load = s1_valid_q && s1_adv;
            always_comb begin
                s2_valid_d = flush ? 1'b0 : s2_load ? 1'b1 : bus.out_ready ? 1'b0 : s2_valid_q;
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_valid_q      <= 1'b0;
                    s2_taken_q      <= 1'b0;
                    s2_mispredict_q <= 1'b0;
                    s2_illegal_q    <= 1'b0;
                    s2_redirect_q   <= '0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    if (s2_load) begin
                        s2_taken_q      <= d_taken;
                        s2_mispredict_q <= d_mispredict;
                        s2_illegal_q    <= d_illegal;
                        s2_redirect_q   <= d_redirect;
                    end
                end
            end
            assign bus.out_valid   = s2_valid_q;
            assign bus.taken       = s2_taken_q;
            assign bus.mispredict  = s2_mispredict_q;
            assign bus.illegal     = s2_illegal_q;
            assign bus.redirect_pc = s2_redirect_q;
        end else begin : g_lat1
            assign s1_adv          = bus.out_ready;
            assign bus.out_valid   = s1_valid_q;
            assign bus.taken       = d_taken;
            assign bus.mispredict  = d_mispredict;
            assign bus.illegal     = d_illegal;
            assign bus.redirect_pc = d_redirect;
        end
    endgenerate

`ifdef BRU_STATS_EN
    logic        out_fire;
    logic [31:0] stat_branches_q, stat_mispred_q;
    assign out_fire = bus.out_valid && bus.out_ready;
    // counters saturate by adding zero once all ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else if (stat_clr) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else if (out_fire) begin
            stat_branches_q <= stat_branches_q + {31'd0, ~&stat_branches_q};
            stat_mispred_q  <= stat_mispred_q + {31'd0, bus.mispredict && ~&stat_mispred_q};
        end
    end
    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_branches   = '0;
    assign stat_mispred    = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: randomized and directed checks of both LATENCY builds against a queue model
module tb_branch_resolve_unit;
    localparam int XLEN = 32;
`ifdef BRU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] redirect;
        logic            mispredict;
        logic            illegal;
    } res_t;
    typedef struct packed {
        logic [2:0]      f;
        logic [XLEN-1:0] a, b, p, i;
        logic            pt;
        logic [XLEN-1:0] ptg;
        logic            et;
        logic [XLEN-1:0] er;
        logic            em, ei;
    } vec_t;

    vec_t dv [9] = '{
        '{3'd4, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0, 1'b1, 32'h120, 1'b1, 1'b0},
        '{3'd6, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, 1'b0},
        '{3'd5, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, 1'b0},
        '{3'd7, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0, 1'b1, 32'h120, 1'b1, 1'b0},
        '{3'd0, 32'h5, 32'h5, 32'hFFFF_FFF0, 32'h20, 1'b1, 32'h10, 1'b1, 32'h10, 1'b0, 1'b0},
        '{3'd2, 32'h5, 32'h5, 32'h100, 32'h20, 1'b1, 32'h120, 1'b0, 32'h104, 1'b0, 1'b1},
        '{3'd1, 32'h3, 32'h3, 32'h100, 32'h20, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, 1'b0},
        '{3'd0, 32'h7, 32'h7, 32'h100, 32'h20, 1'b1, 32'h124, 1'b1, 32'h120, 1'b1, 1'b0},
        '{3'd4, 32'h1, 32'hFFFF_FFFF, 32'h100, 32'hFFFF_FFFC, 1'b1, 32'hFC, 1'b0, 32'h104, 1'b1, 1'b0}
    };

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, stat_clr = 1'b0, sel = 1'b0;
    logic in_valid = 1'b0, pred_taken = 1'b0, out_ready = 1'b0;
    logic [2:0] funct3 = '0;
    logic [XLEN-1:0] rs1 = '0, rs2 = '0, pc = '0, imm = '0, pred_target = '0;
    logic in_ready, out_valid, taken, mispredict, illegal;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0] stat_br, stat_mp, sb1, sm1, sb2, sm2;

    int n_vec = 0, n_err = 0, spurious = 0, accepted = 0;
    int unsigned m_br [2] = '{0, 0};
    int unsigned m_mp [2] = '{0, 0};
    res_t exp_q [$], done_q [$], obs_q [$];

    branch_resolve_unit_if #(.XLEN(XLEN)) bus1 ();
    branch_resolve_unit_if #(.XLEN(XLEN)) bus2 ();

    assign bus1.in_valid = in_valid && !sel;
    assign bus2.in_valid = in_valid && sel;
    assign bus1.out_ready = out_ready && !sel;
    assign bus2.out_ready = out_ready && sel;
    assign bus1.funct3 = funct3;
    assign bus2.funct3 = funct3;
    assign bus1.rs1 = rs1;
    assign bus2.rs1 = rs1;
    assign bus1.rs2 = rs2;
    assign bus2.rs2 = rs2;
    assign bus1.pc = pc;
    assign bus2.pc = pc;
    assign bus1.imm = imm;
    assign bus2.imm = imm;
    assign bus1.pred_taken = pred_taken;
    assign bus2.pred_taken = pred_taken;
    assign bus1.pred_target = pred_target;
    assign bus2.pred_target = pred_target;
    assign in_ready    = sel ? bus2.in_ready : bus1.in_ready;
    assign out_valid   = sel ? bus2.out_valid : bus1.out_valid;
    assign taken       = sel ? bus2.taken : bus1.taken;
    assign redirect_pc = sel ? bus2.redirect_pc : bus1.redirect_pc;
    assign mispredict  = sel ? bus2.mispredict : bus1.mispredict;
    assign illegal     = sel ? bus2.illegal : bus1.illegal;
    assign stat_br     = sel ? sb2 : sb1;
    assign stat_mp     = sel ? sm2 : sm1;

    branch_resolve_unit #(.XLEN(XLEN), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .flush(flush && !sel), .stat_clr(stat_clr && !sel),
        .stat_branches(sb1), .stat_mispred(sm1), .bus(bus1.slave)
    );
    branch_resolve_unit #(.XLEN(XLEN), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst), .flush(flush && sel), .stat_clr(stat_clr && sel),
        .stat_branches(sb2), .stat_mispred(sm2), .bus(bus2.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1);
    end

    function automatic res_t model(input logic [2:0] f, input logic [XLEN-1:0] a, b, p, i,
                                   input logic pt, input logic [XLEN-1:0] ptg);
        res_t r;
        logic [XLEN-1:0] tgt;
        tgt = p + i;
        r.illegal = (f == 3'd2) || (f == 3'd3);
        case (f)
            3'd0: r.taken = a == b;
            3'd1: r.taken = a != b;
            3'd4: r.taken = $signed(a) < $signed(b);
            3'd5: r.taken = $signed(a) >= $signed(b);
            3'd6: r.taken = a < b;
            3'd7: r.taken = a >= b;
            default: r.taken = 1'b0;
        endcase
        r.redirect = r.taken ? tgt : p + 32'd4;
        r.mispredict = !r.illegal && ((r.taken != pt) || (r.taken && ptg != tgt));
        return r;
    endfunction

    // one clock: record what the coming edge transfers, then move to the next falling edge
    task automatic tick();
        res_t e;
        #1;
        if (in_valid && in_ready) begin
            exp_q.push_back(model(funct3, rs1, rs2, pc, imm, pred_taken, pred_target));
            accepted++;
        end
        if (out_valid && out_ready) begin
            obs_q.push_back('{taken, redirect_pc, mispredict, illegal});
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                done_q.push_back(e);
                if (!stat_clr) begin
                    m_br[sel]++;
                    if (e.mispredict) m_mp[sel]++;
                end
            end else spurious++;
        end
        if (stat_clr) begin
            m_br[sel] = 0;
            m_mp[sel] = 0;
        end
        if (flush) exp_q.delete();
        @(negedge clk);
    endtask

    task automatic set_in(input vec_t v);
        funct3 = v.f; rs1 = v.a; rs2 = v.b; pc = v.p; imm = v.i;
        pred_taken = v.pt; pred_target = v.ptg;
    endtask

    task automatic rand_in();
        funct3 = 3'($urandom_range(0, 7));
        rs1 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 4);
        rs2 = $urandom_range(0, 3) == 0 ? rs1 : ($urandom_range(0, 1) ? $urandom : $urandom_range(0, 4));
        pc = $urandom & ~32'd3;
        imm = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 4095));
        pred_taken = 1'($urandom_range(0, 1));
        pred_target = $urandom_range(0, 1) ? pc + imm : $urandom;
    endtask

    task automatic drain(output bit ok);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick();
        ok = exp_q.size() == 0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        out_ready = 1'b0;
        rand_in();
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_vec++;
        if ({out_valid, taken, mispredict, illegal, redirect_pc} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs sel=%0d got v=%b t=%b m=%b i=%b pc=%h required all 0",
                     sel, out_valid, taken, mispredict, illegal, redirect_pc);
        end
        n_vec++;
        if ({stat_br, stat_mp} !== 64'd0) begin
            n_err++;
            $display("FAIL reset_stats sel=%0d got %0d/%0d required 0/0", sel, stat_br, stat_mp);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        exp_q.delete(); done_q.delete(); obs_q.delete();
        m_br = '{0, 0};
        m_mp = '{0, 0};
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready sel=%0d got in_ready=%b out_valid=%b required 1/0", sel, in_ready, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        int lat;
        res_t req;
        for (int v = 0; v < 9; v++) begin
            set_in(dv[v]);
            in_valid = 1'b1;
            out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 6) begin
                tick();
                lat++;
            end
            n_vec++;
            if (lat != sel + 1) begin
                n_err++;
                $display("FAIL latency sel=%0d vec=%0d got %0d edges required %0d", sel, v, lat, sel + 1);
            end
            tick();
            req = '{dv[v].et, dv[v].er, dv[v].em, dv[v].ei};
            n_vec++;
            if (obs_q.size() != 1) begin
                n_err++;
                $display("FAIL directed_count sel=%0d vec=%0d got %0d results required 1", sel, v, obs_q.size());
            end else if (obs_q[0] !== req) begin
                n_err++;
                $display("FAIL directed sel=%0d vec=%0d got t=%b pc=%h m=%b i=%b required t=%b pc=%h m=%b i=%b",
                         sel, v, obs_q[0].taken, obs_q[0].redirect, obs_q[0].mispredict, obs_q[0].illegal,
                         req.taken, req.redirect, req.mispredict, req.illegal);
            end
            obs_q.delete(); done_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_stream();
        int base;
        bit stalled;
        logic [XLEN+3:0] snap;
        base = accepted;
        stalled = 1'b0;
        snap = '0;
        spurious = 0;
        for (int c = 0; c < 600 && (accepted - base < 48 || exp_q.size() > 0); c++) begin
            rand_in();
            in_valid = (accepted - base < 8) ? 1'b1 : (accepted - base < 48) ? ($urandom_range(0, 3) != 0) : 1'b0;
            out_ready = (c < 16) ? !(c >= 3 && c <= 5) : (accepted - base >= 48) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (stalled) begin
                n_vec++;
                if ({out_valid, taken, redirect_pc, mispredict, illegal} !== snap) begin
                    n_err++;
                    $display("FAIL stall_hold sel=%0d cycle=%0d got %h required %h", sel, c,
                             {out_valid, taken, redirect_pc, mispredict, illegal}, snap);
                end
            end
            stalled = out_valid && !out_ready;
            snap = {out_valid, taken, redirect_pc, mispredict, illegal};
            tick();
        end
        n_vec++;
        if (obs_q.size() != 48 || done_q.size() != 48 || spurious != 0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL stream_count sel=%0d got obs=%0d matched=%0d extra=%0d pending=%0d required 48/48/0/0",
                     sel, obs_q.size(), done_q.size(), spurious, exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < done_q.size(); k++) begin
            n_vec++;
            if (obs_q[k] !== done_q[k]) begin
                n_err++;
                $display("FAIL stream sel=%0d idx=%0d got t=%b pc=%h m=%b i=%b required t=%b pc=%h m=%b i=%b",
                         sel, k, obs_q[k].taken, obs_q[k].redirect, obs_q[k].mispredict, obs_q[k].illegal,
                         done_q[k].taken, done_q[k].redirect, done_q[k].mispredict, done_q[k].illegal);
            end
        end
        obs_q.delete(); done_q.delete();
    endtask

    task automatic test_flush();
        int unsigned br0;
        br0 = m_br[sel];
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rand_in();
            tick();
        end
        rand_in();
        flush = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ready sel=%0d got in_ready=%b required 0", sel, in_ready);
        end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_valid sel=%0d got out_valid=%b required 0", sel, out_valid);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        n_vec++;
        if (obs_q.size() != 0 || m_br[sel] != br0) begin
            n_err++;
            $display("FAIL flush_drop sel=%0d got %0d results required 0", sel, obs_q.size());
        end
        n_vec++;
        if (stat_br !== (STATS ? br0 : 32'd0)) begin
            n_err++;
            $display("FAIL flush_stats sel=%0d got %0d required %0d", sel, stat_br, STATS ? br0 : 0);
        end
        obs_q.delete(); done_q.delete();
    endtask

    task automatic test_stats();
        bit ok;
        out_ready = 1'b1;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        n_vec++;
        if ({stat_br, stat_mp} !== 64'd0) begin
            n_err++;
            $display("FAIL stat_clr sel=%0d got %0d/%0d required 0/0", sel, stat_br, stat_mp);
        end
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_in(dv[k]);
            for (int w = 0; w < 5 && !in_ready; w++) tick();
            tick();
        end
        drain(ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL stats_drain sel=%0d got %0d pending required 0", sel, exp_q.size());
        end
        n_vec++;
        if (stat_br !== (STATS ? 32'd5 : 32'd0) || stat_mp !== (STATS ? 32'd2 : 32'd0)) begin
            n_err++;
            $display("FAIL stats_count sel=%0d got %0d/%0d required %0d/%0d", sel, stat_br, stat_mp,
                     STATS ? 5 : 0, STATS ? 2 : 0);
        end
        set_in(dv[0]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int w = 0; w < 5 && !out_valid; w++) tick();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        n_vec++;
        if ({stat_br, stat_mp} !== 64'd0 || m_br[sel] != 0) begin
            n_err++;
            $display("FAIL stat_clr_beats_inc sel=%0d got %0d/%0d required 0/0", sel, stat_br, stat_mp);
        end
        obs_q.delete(); done_q.delete(); exp_q.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            test_reset();
            test_directed();
            test_stream();
            test_flush();
            test_stats();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
